// File: rtl/vc_arbiter_pkg.sv
// Shared definitions for the two-VC arbiter: FSM encoding, destination bit
// position inside a head word, and the default starvation limit.
package vc_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_t;

    localparam int DEST_BIT         = 4;
    localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/vc_grant_sel.sv
// Combinational eligibility and priority selection between VC0 and VC1.
// VC0 wins unless the starvation counter has reached its limit and VC1 is eligible.
module vc_grant_sel
    import vc_arbiter_pkg::*;
#(
    parameter int DATA_W = 6
) (
    input  logic              reset,
    input  logic              enable,
    input  logic              vc0_empty,
    input  logic              vc1_empty,
    input  logic [DATA_W-1:0] vc0_data,
    input  logic [DATA_W-1:0] vc1_data,
    input  logic              d0_almost_full,
    input  logic              d1_almost_full,
    input  logic              starve_hit,
    output logic              elig1,
    output logic              gnt0,
    output logic              gnt1
);

    logic blk0;
    logic blk1;
    logic elig0;

    always_comb begin
        blk0  = vc0_data[DEST_BIT] ? d1_almost_full : d0_almost_full;
        blk1  = vc1_data[DEST_BIT] ? d1_almost_full : d0_almost_full;
        elig0 = enable & ~vc0_empty & ~blk0;
        elig1 = enable & ~vc1_empty & ~blk1;
        // Reset gates the strobes here so no FIFO is popped while reset is held.
        gnt0  = ~reset & elig0 & ~(starve_hit & elig1);
        gnt1  = ~reset & elig1 & ~gnt0;
    end

endmodule

// File: rtl/vc_arbiter.sv
// Two-VC arbiter feeding two destination FIFOs: combinational pops, registered
// pushes one cycle later, with starvation protection for VC1.
module vc_arbiter
    import vc_arbiter_pkg::*;
#(
    parameter int BW           = 6,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          vc0_empty,
    input  logic          vc1_empty,
    input  logic [BW-1:0] vc0_data,
    input  logic [BW-1:0] vc1_data,
    input  logic          d0_almost_full,
    input  logic          d1_almost_full,
    output logic          vc0_pop,
    output logic          vc1_pop,
    output logic          d0_push,
    output logic          d1_push,
    output logic [BW-1:0] d_data,
    output logic          idle
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t state;
    arb_state_t state_nxt;

    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_cnt_nxt;
    logic             starve_hit;
    logic             elig1;
    logic             gnt0;
    logic             gnt1;

    logic [BW-1:0]    word_p0;
    logic             vld_p0;
    logic             dest_p0;
    logic [BW-1:0]    data_p1;
    logic             push0_p1;
    logic             push1_p1;
    logic             idle_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_W'(STARVE_LIMIT)) ? c : c + CNT_W'(1);
    endfunction

    assign starve_hit = (starve_cnt == CNT_W'(STARVE_LIMIT));

    vc_grant_sel #(.DATA_W(BW)) u_sel (
        .reset          (reset),
        .enable         (enable),
        .vc0_empty      (vc0_empty),
        .vc1_empty      (vc1_empty),
        .vc0_data       (vc0_data),
        .vc1_data       (vc1_data),
        .d0_almost_full (d0_almost_full),
        .d1_almost_full (d1_almost_full),
        .starve_hit     (starve_hit),
        .elig1          (elig1),
        .gnt0           (gnt0),
        .gnt1           (gnt1)
    );

    assign vc0_pop = gnt0;
    assign vc1_pop = gnt1;

    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        vld_p0         = gnt0 | gnt1;
        word_p0        = gnt1 ? vc1_data : vc0_data;
        dest_p0        = word_p0[DEST_BIT];

        unique case (state)
            ST_IDLE: if (enable && !(vc0_empty && vc1_empty)) state_nxt = ST_RUN;
            ST_RUN:  if (!enable || (vc0_empty && vc1_empty)) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase

        if (gnt1 || !elig1)
            starve_cnt_nxt = '0;
        else if (gnt0)
            starve_cnt_nxt = sat_inc(starve_cnt);
    end

    // p0 -> p1: grant cycle registers the popped word and its destination strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
            push0_p1   <= 1'b0;
            push1_p1   <= 1'b0;
            data_p1    <= '0;
            idle_p1    <= 1'b1;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
            push0_p1   <= vld_p0 & ~dest_p0;
            push1_p1   <= vld_p0 & dest_p0;
            if (vld_p0)
                data_p1 <= word_p0;
            idle_p1    <= (state_nxt == ST_IDLE) & ~vld_p0;
        end
    end

    // A push owed when reset rises is dropped rather than delivered.
    assign d0_push = push0_p1 & ~reset;
    assign d1_push = push1_p1 & ~reset;
    assign d_data  = data_p1;
    assign idle    = idle_p1;

endmodule
